// File: rtl/adc_cfg_pkg.sv
// Shared encodings for the ADC configuration sequencer: FSM states,
// transaction classes, command-word layout and the init table entry type.
package adc_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_ADC_RST  = 3'd0;
  localparam state_t ST_ADC_WAIT = 3'd1;
  localparam state_t ST_FETCH    = 3'd2;
  localparam state_t ST_ACC      = 3'd3;
  localparam state_t ST_GAP      = 3'd4;
  localparam state_t ST_CHECK    = 3'd5;
  localparam state_t ST_IDLE     = 3'd6;

  typedef enum logic [1:0] {
    CLS_INIT_WR = 2'd0,
    CLS_INIT_RD = 2'd1,
    CLS_HOST    = 2'd2
  } txn_class_t;

  localparam int CMD_ACCESS   = 0;
  localparam int CMD_RW       = 1;
  localparam int CMD_RSTN     = 2;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_ADDR_MSB = 14;
  localparam int CMD_DATA_LSB = 16;
  localparam int CMD_DATA_MSB = 31;

  // ADC out of reset, no access in flight
  localparam logic [31:0] CMD_QUIET = 32'h0000_0004;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } rom_entry_t;

  function automatic logic [31:0] build_cmd(input logic [15:0] data,
                                            input logic [6:0]  addr,
                                            input logic        rw,
                                            input logic        access);
    logic [31:0] cmd;
    cmd = '0;
    cmd[CMD_DATA_MSB:CMD_DATA_LSB] = data;
    cmd[CMD_ADDR_MSB:CMD_ADDR_LSB] = addr;
    cmd[CMD_RSTN]   = 1'b1;
    cmd[CMD_RW]     = rw;
    cmd[CMD_ACCESS] = access;
    return cmd;
  endfunction

endpackage

// File: rtl/adc_cfg_sequencer_rom.sv
// Init register table for the ADS5401: registered lookup of {addr, data}
// by init index; indices at or beyond INIT_LEN read as zero.
module adc_init_rom
  import adc_cfg_pkg::*;
#(
  parameter int INIT_LEN = 8
) (
  input  logic       clk,
  input  logic [6:0] index,
  output rom_entry_t entry
);

  rom_entry_t lookup;

  always_comb begin
    lookup = '0;
    case (index)
      7'd0:    lookup = '{addr: 7'h01, data: 16'h8A0C};
      7'd1:    lookup = '{addr: 7'h02, data: 16'h0030};
      7'd2:    lookup = '{addr: 7'h03, data: 16'h1F40};
      7'd3:    lookup = '{addr: 7'h04, data: 16'h0002};
      7'd4:    lookup = '{addr: 7'h05, data: 16'h00C0};
      7'd5:    lookup = '{addr: 7'h0A, data: 16'h0101};
      7'd6:    lookup = '{addr: 7'h0E, data: 16'h3C3C};
      7'd7:    lookup = '{addr: 7'h38, data: 16'h8000};
      default: lookup = '0;
    endcase
    if (int'(index) >= INIT_LEN) lookup = '0;
  end

  always_ff @(posedge clk) begin
    entry <= lookup;
  end

endmodule

// File: rtl/adc_cfg_sequencer.sv
// Resets and configures the ADC through the serial-interface block, then
// arbitrates single host register accesses onto the same command word.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int INIT_LEN   = 8,
  parameter int T_ACC      = 64,
  parameter int T_GAP      = 320,
  parameter int RST_CYCLES = 256,
  parameter int RST_WAIT   = 1024,
  parameter int VERIFY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] adc_cmd,
  input  logic [31:0] adc_rdata,
  input  logic        reinit,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  err_cnt
);

  state_t      state;
  txn_class_t  cls;
  logic [15:0] timer;
  logic [6:0]  index;
  logic [15:0] rd_q;
  logic        hold_rw;
  logic [6:0]  hold_addr;
  logic [15:0] hold_wdata;
  rom_entry_t  rom_q;

  logic        last_tick;
  logic        last_index;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_rw;
  logic        unused_rdata_hi;

  adc_init_rom #(
    .INIT_LEN (INIT_LEN)
  ) u_rom (
    .clk   (clk),
    .index (index),
    .entry (rom_q)
  );

  assign last_tick       = (timer == 16'd1);
  assign last_index      = (index == 7'(INIT_LEN - 1));
  assign busy            = (state != ST_IDLE);
  assign unused_rdata_hi = ^adc_rdata[31:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ADC_RST;
      cls        <= CLS_INIT_WR;
      timer      <= 16'(RST_CYCLES);
      index      <= '0;
      rd_q       <= '0;
      hold_rw    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      cfg_done   <= 1'b0;
      cfg_error  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      host_ack <= 1'b0;
      if (timer != 16'd0) timer <= timer - 16'd1;

      case (state)
        ST_ADC_RST: begin
          if (last_tick) begin
            state <= ST_ADC_WAIT;
            timer <= 16'(RST_WAIT);
          end
        end

        ST_ADC_WAIT: begin
          if (last_tick) begin
            state <= ST_FETCH;
            index <= '0;
          end
        end

        ST_FETCH: begin
          state <= ST_ACC;
          cls   <= CLS_INIT_WR;
          timer <= 16'(T_ACC);
        end

        ST_ACC: begin
          if (last_tick) begin
            state <= ST_GAP;
            timer <= 16'(T_GAP);
          end
        end

        // The serial block has finished shifting and latching by the last
        // GAP cycle, so that is where the read result is taken.
        ST_GAP: begin
          if (last_tick) begin
            rd_q <= adc_rdata[15:0];
            case (cls)
              CLS_INIT_WR: begin
                if (VERIFY != 0) begin
                  state <= ST_ACC;
                  cls   <= CLS_INIT_RD;
                  timer <= 16'(T_ACC);
                end else if (last_index) begin
                  cfg_done <= 1'b1;
                  state    <= ST_IDLE;
                end else begin
                  index <= index + 7'd1;
                  state <= ST_FETCH;
                end
              end
              CLS_INIT_RD: begin
                state <= ST_CHECK;
              end
              default: begin
                host_ack <= 1'b1;
                if (hold_rw) host_rdata <= adc_rdata[15:0];
                state <= ST_IDLE;
              end
            endcase
          end
        end

        ST_CHECK: begin
          if (rd_q != rom_q.data) begin
            cfg_error <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
          if (last_index) begin
            cfg_done <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            index <= index + 7'd1;
            state <= ST_FETCH;
          end
        end

        // The ack cycle counts as the tail of the host transaction, so a
        // request still held by the host is not re-accepted until after it.
        ST_IDLE: begin
          if (!host_ack) begin
            if (reinit) begin
              state     <= ST_ADC_RST;
              timer     <= 16'(RST_CYCLES);
              cfg_done  <= 1'b0;
              cfg_error <= 1'b0;
              err_cnt   <= '0;
            end else if (host_req) begin
              hold_rw    <= host_rw;
              hold_addr  <= host_addr;
              hold_wdata <= host_wdata;
              cls        <= CLS_HOST;
              state      <= ST_ACC;
              timer      <= 16'(T_ACC);
            end
          end
        end

        default: begin
          state <= ST_ADC_RST;
          timer <= 16'(RST_CYCLES);
        end
      endcase
    end
  end

  always_comb begin
    cmd_addr = rom_q.addr;
    cmd_data = rom_q.data;
    cmd_rw   = 1'b0;
    case (cls)
      CLS_INIT_RD: cmd_rw = 1'b1;
      CLS_HOST: begin
        cmd_addr = hold_addr;
        cmd_data = hold_wdata;
        cmd_rw   = hold_rw;
      end
      default: cmd_rw = 1'b0;
    endcase

    case (state)
      ST_ADC_RST: adc_cmd = '0;
      ST_ACC:     adc_cmd = build_cmd(cmd_data, cmd_addr, cmd_rw, 1'b1);
      ST_GAP:     adc_cmd = build_cmd(cmd_data, cmd_addr, cmd_rw, 1'b0);
      default:    adc_cmd = CMD_QUIET;
    endcase
  end

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Scoreboard bench: a verifying sequencer and a non-verifying one, each
// talking to a behavioural serial-interface model that echoes written data.
module tb_adc_cfg_sequencer;

  typedef struct {
    logic [31:0] cmd;
    int          rel;
  } txn_t;

  typedef struct {
    logic [15:0] rdata;
    int          rel;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] adc_cmd;
  logic [31:0] adc_rdata = '0;
  logic        reinit;
  logic        host_req;
  logic        host_rw;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [7:0]  err_cnt;

  logic [31:0] nv_cmd;
  logic [31:0] nv_rdata = '0;
  logic        nv_ack;
  logic [15:0] nv_host_rdata;
  logic        nv_busy;
  logic        nv_cfg_done;
  logic        nv_cfg_error;
  logic [7:0]  nv_err_cnt;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  int nv_rd = 0;
  int nv_wr = 0;

  txn_t txn_q[$];
  ack_t ack_q[$];

  logic [6:0]  rom_a [3] = '{7'h01, 7'h02, 7'h03};
  logic [15:0] rom_d [3] = '{16'h8A0C, 16'h0030, 16'h1F40};

  logic          corrupt = 1'b0;
  logic [15:0]   mem [128];
  logic [127:0]  written = '0;
  logic          m_prev = 1'b0;
  logic [15:0]   mem2 [128];
  logic [127:0]  written2 = '0;
  logic          m2_prev = 1'b0;
  logic          mon_prev = 1'b0;
  logic          nv_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_cfg_sequencer #(
    .INIT_LEN(3), .T_ACC(4), .T_GAP(8), .RST_CYCLES(16), .RST_WAIT(16), .VERIFY(1)
  ) dut (
    .clk(clk), .reset(reset), .adc_cmd(adc_cmd), .adc_rdata(adc_rdata),
    .reinit(reinit), .host_req(host_req), .host_rw(host_rw),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .busy(busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .err_cnt(err_cnt)
  );

  adc_cfg_sequencer #(
    .INIT_LEN(3), .T_ACC(4), .T_GAP(8), .RST_CYCLES(16), .RST_WAIT(16), .VERIFY(0)
  ) dut_nv (
    .clk(clk), .reset(reset), .adc_cmd(nv_cmd), .adc_rdata(nv_rdata),
    .reinit(1'b0), .host_req(1'b0), .host_rw(1'b0),
    .host_addr(7'h00), .host_wdata(16'h0000), .host_ack(nv_ack),
    .host_rdata(nv_host_rdata), .busy(nv_busy), .cfg_done(nv_cfg_done),
    .cfg_error(nv_cfg_error), .err_cnt(nv_err_cnt)
  );

  // Serial-interface model: acts once per access pulse; unwritten registers
  // read as 0xBE00 | addr, the upper half of the result is junk.
  always @(posedge clk) begin
    if (adc_cmd[0] && !m_prev) begin
      if (!adc_cmd[1]) begin
        mem[adc_cmd[14:8]]     <= adc_cmd[31:16];
        written[adc_cmd[14:8]] <= 1'b1;
      end else begin
        adc_rdata <= {16'hDEAD,
                      (written[adc_cmd[14:8]] ? mem[adc_cmd[14:8]] : {9'h17C, adc_cmd[14:8]})
                      ^ ((corrupt && adc_cmd[14:8] == 7'h02) ? 16'h0001 : 16'h0000)};
      end
    end
    m_prev <= adc_cmd[0];
  end

  // Model for the non-verifying instance always corrupts reads.
  always @(posedge clk) begin
    if (nv_cmd[0] && !m2_prev) begin
      if (!nv_cmd[1]) begin
        mem2[nv_cmd[14:8]]     <= nv_cmd[31:16];
        written2[nv_cmd[14:8]] <= 1'b1;
      end else begin
        nv_rdata <= {16'h0000,
                     (written2[nv_cmd[14:8]] ? mem2[nv_cmd[14:8]] : 16'h0000) ^ 16'hFFFF};
      end
    end
    m2_prev <= nv_cmd[0];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  function automatic logic [31:0] mk(input logic [15:0] d, input logic [6:0] a, input logic rw);
    return {d, 1'b0, a, 5'b00000, 1'b1, rw, 1'b1};
  endfunction

  task automatic pushTxn(input logic [31:0] cmd, input int rel);
    txn_t t;
    t.cmd = cmd;
    t.rel = rel;
    txn_q.push_back(t);
  endtask

  task automatic pushAck(input logic [15:0] rdata, input int rel);
    ack_t a;
    a.rdata = rdata;
    a.rel   = rel;
    ack_q.push_back(a);
  endtask

  // Entry k: FETCH at 32+26k, write access at 33+26k, readback at 45+26k.
  task automatic pushInit();
    for (int k = 0; k < 3; k++) begin
      pushTxn(mk(rom_d[k], rom_a[k], 1'b0), 33 + 26 * k);
      pushTxn(mk(rom_d[k], rom_a[k], 1'b1), 45 + 26 * k);
    end
  endtask

  task automatic waitRel(input int r);
    while ((cyc - base) < r) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                               input logic [15:0] wdata, input logic with_reinit);
    host_req   = 1'b1;
    host_rw    = rw;
    host_addr  = addr;
    host_wdata = wdata;
    reinit     = with_reinit;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_cmd", adc_cmd, 32'h0);
    checkOutput("rst_ack", 32'(host_ack), 32'h0);
    checkOutput("rst_rdata", 32'(host_rdata), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h1);
    checkOutput("rst_done", 32'(cfg_done), 32'h0);
    checkOutput("rst_error", 32'(cfg_error), 32'h0);
    checkOutput("rst_errcnt", 32'(err_cnt), 32'h0);
    reset = 1'b0;
    base  = cyc;
  endtask

  // Monitor: pops the expected transaction on each access rising edge and
  // the expected host response on each ack.
  always @(negedge clk) begin
    txn_t e;
    ack_t a;
    if (!reset) begin
      if (adc_cmd[0] && !mon_prev) begin
        if (txn_q.size() == 0) begin
          checkOutput("unexpected_txn", adc_cmd, 32'h0);
        end else begin
          e = txn_q.pop_front();
          checkOutput("txn_cmd", adc_cmd, e.cmd);
          checkOutput("txn_cycle", 32'(cyc - base), 32'(e.rel));
        end
      end
      if (host_ack) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected_ack", 32'(host_ack), 32'h0);
        end else begin
          a = ack_q.pop_front();
          checkOutput("ack_rdata", 32'(host_rdata), 32'(a.rdata));
          checkOutput("ack_cycle", 32'(cyc - base), 32'(a.rel));
        end
      end
    end
    mon_prev = adc_cmd[0];
  end

  always @(negedge clk) begin
    if (nv_cmd[0] && !nv_prev) begin
      if (nv_cmd[1]) nv_rd++;
      else nv_wr++;
    end
    nv_prev = nv_cmd[0];
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    host_req = 1'b0; host_rw = 1'b0; host_addr = '0; host_wdata = '0; reinit = 1'b0;

    // Clean init with a host read held from mid-init
    doReset();
    pushInit();
    waitRel(15);  checkOutput("adc_rst_hold", adc_cmd, 32'h0);
    waitRel(16);  checkOutput("adc_rst_release", adc_cmd, 32'h4);
    waitRel(60);
    applyStimulus(1'b1, 7'h2A, 16'h0000, 1'b0);
    pushTxn(32'h0000_2A07, 111);
    pushAck(16'hBE2A, 123);
    waitRel(70);  checkOutput("nv_done_early", 32'(nv_cfg_done), 32'h0);
    waitRel(71);
    checkOutput("nv_done", 32'(nv_cfg_done), 32'h1);
    checkOutput("nv_errcnt", 32'(nv_err_cnt), 32'h0);
    checkOutput("nv_error", 32'(nv_cfg_error), 32'h0);
    waitRel(100); checkOutput("host_deferred", 32'(host_ack), 32'h0);
    waitRel(109); checkOutput("done_early", 32'(cfg_done), 32'h0);
    waitRel(110);
    checkOutput("init_done", 32'(cfg_done), 32'h1);
    checkOutput("init_errcnt", 32'(err_cnt), 32'h0);
    checkOutput("init_error", 32'(cfg_error), 32'h0);
    checkOutput("idle_busy", 32'(busy), 32'h0);
    checkOutput("nv_reads", 32'(nv_rd), 32'h0);
    checkOutput("nv_writes", 32'(nv_wr), 32'h3);
    waitRel(123);
    host_req = 1'b0;

    // Reinit with entry-1 readback corrupted
    waitRel(130);
    corrupt = 1'b1;
    reinit  = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    base   = cyc;
    pushInit();
    waitRel(83);  checkOutput("corrupt_errcnt_pre", 32'(err_cnt), 32'h0);
    waitRel(84);  checkOutput("corrupt_errcnt_post", 32'(err_cnt), 32'h1);
    waitRel(110);
    checkOutput("corrupt_done", 32'(cfg_done), 32'h1);
    checkOutput("corrupt_error", 32'(cfg_error), 32'h1);
    checkOutput("corrupt_errcnt", 32'(err_cnt), 32'h1);

    // reinit and host write in the same IDLE cycle
    waitRel(130);
    corrupt = 1'b0;
    applyStimulus(1'b0, 7'h10, 16'h1234, 1'b1);
    @(negedge clk);
    reinit = 1'b0;
    base   = cyc;
    pushInit();
    pushTxn(32'h1234_1005, 111);
    pushAck(16'hBE2A, 123);
    checkOutput("reinit_done_clr", 32'(cfg_done), 32'h0);
    checkOutput("reinit_error_clr", 32'(cfg_error), 32'h0);
    checkOutput("reinit_errcnt_clr", 32'(err_cnt), 32'h0);
    waitRel(110);
    checkOutput("reinit_done", 32'(cfg_done), 32'h1);
    checkOutput("reinit_error", 32'(cfg_error), 32'h0);
    waitRel(123);
    host_req = 1'b0;
    waitRel(125); checkOutput("write_keeps_error", 32'(cfg_error), 32'h0);

    // Reset in the GAP of a host write
    waitRel(130);
    applyStimulus(1'b0, 7'h11, 16'h5555, 1'b0);
    pushTxn(32'h5555_1105, 131);
    waitRel(137);
    host_req = 1'b0;
    doReset();
    pushInit();
    waitRel(110); checkOutput("restart_done", 32'(cfg_done), 32'h1);
    waitRel(130);

    checkOutput("txn_queue_empty", 32'(txn_q.size()), 32'h0);
    checkOutput("ack_queue_empty", 32'(ack_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
